// File: rtl/ltc2195_pkg.sv
// Shared definitions for the LTC2195 power-up / re-train sequencer:
// FSM state encodings, ADC SPI register map and command-table indices.
package ltc2195_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_GAP    = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_CHECK  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_FAIL   = 3'd6;

    localparam logic [15:0] REG_RESET  = 16'h0000;
    localparam logic [15:0] REG_TP_MSB = 16'h0003;
    localparam logic [15:0] REG_TP_LSB = 16'h0004;

    localparam int          OUTTEST_BIT     = 7;
    localparam logic [15:0] SOFT_RESET_DATA = 16'h0080;

    localparam logic [1:0] CMD_SOFT_RESET = 2'd0;
    localparam logic [1:0] CMD_TP_LSB     = 2'd1;
    localparam logic [1:0] CMD_TP_ON      = 2'd2;
    localparam logic [1:0] CMD_TP_OFF     = 2'd3;

endpackage

// File: rtl/ltc2195_cmd_rom.sv
// Combinational command table: maps a command index to the SPI
// register address and data word sent to the LTC2195 block.
module ltc2195_cmd_rom
    import ltc2195_pkg::*;
#(
    parameter logic [15:0] TEST_PATTERN = 16'h2A55
) (
    input  logic [1:0]  idx_i,
    output logic [15:0] addr_o,
    output logic [15:0] data_o
);

    always_comb begin
        addr_o = REG_RESET;
        data_o = SOFT_RESET_DATA;
        case (idx_i)
            CMD_TP_LSB: begin
                addr_o = REG_TP_LSB;
                data_o = {8'h00, TEST_PATTERN[7:0]};
            end
            CMD_TP_ON: begin
                // Pattern MSBs share the register with the OUTTEST enable bit.
                addr_o = REG_TP_MSB;
                data_o = {8'h00, 1'b0, TEST_PATTERN[14:8]};
                data_o[OUTTEST_BIT] = 1'b1;
            end
            CMD_TP_OFF: begin
                addr_o = REG_TP_MSB;
                data_o = 16'h0000;
            end
            default: begin
                addr_o = REG_RESET;
                data_o = SOFT_RESET_DATA;
            end
        endcase
    end

endmodule

// File: rtl/ltc2195_init_seq.sv
// LTC2195 link trainer: soft-resets the ADC, enables its test pattern,
// verifies the deserialised words, then disables the pattern (with retries).
module ltc2195_init_seq
    import ltc2195_pkg::*;
#(
    parameter int          CMD_GAP       = 256,
    parameter int          SETTLE_CYCLES = 1024,
    parameter int          CHECK_COUNT   = 64,
    parameter int          CHECK_TIMEOUT = 8192,
    parameter int          MAX_RETRIES   = 3,
    parameter logic [15:0] TEST_PATTERN  = 16'h2A55,
    parameter logic [3:0]  FR_EXPECT     = 4'b0011
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [15:0] ADC0_in,
    input  logic [15:0] ADC1_in,
    input  logic [3:0]  FR_in,
    output logic        cmd_trig_out,
    output logic [15:0] cmd_addr_out,
    output logic [15:0] cmd_data_out,
    output logic        ready_out,
    output logic        fail_out,
    output logic        frame_err_out,
    output logic [1:0]  retry_out,
    output logic [2:0]  dbg_state_out
);

    localparam int WAIT_MAX = (CMD_GAP > SETTLE_CYCLES) ? CMD_GAP : SETTLE_CYCLES;
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam int MW = $clog2(CHECK_COUNT + 1);
    localparam int TW = $clog2(CHECK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] GAP_LAST    = CW'(CMD_GAP - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_LIM   = MW'(CHECK_COUNT);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(CHECK_TIMEOUT);
    localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRIES);
    // The ADC ignores bit 15 of the programmed pattern and sends it as 0.
    localparam logic [15:0]   EXP_WORD    = {1'b0, TEST_PATTERN[14:0]};

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] match_q, match_d, match_inc, match_nx;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [RW-1:0] retry_q, retry_d;
    logic          trig_q, trig_d;
    logic [15:0]   addr_q, addr_d, data_q, data_d;
    logic          ready_q, ready_d, fail_q, fail_d, ferr_q, ferr_d;
    logic [15:0]   rom_addr, rom_data;
    logic          word_ok;

    ltc2195_cmd_rom #(.TEST_PATTERN(TEST_PATTERN)) u_rom (
        .idx_i  (idx_d),
        .addr_o (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        word_ok   = (ADC0_in == EXP_WORD) && (ADC1_in == EXP_WORD) && (FR_in == FR_EXPECT);
        match_inc = (match_q == MATCH_LIM) ? match_q : match_q + MW'(1);
        match_nx  = word_ok ? match_inc : '0;
        tmo_inc   = (tmo_q == TIMEOUT_LIM) ? tmo_q : tmo_q + TW'(1);

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_d = ready_q;
        fail_d  = fail_q;
        ferr_d  = ferr_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_CMD;
                idx_d   = CMD_SOFT_RESET;
            end
            ST_CMD: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d = '0;
                    case (idx_q)
                        CMD_SOFT_RESET: begin state_d = ST_CMD; idx_d = CMD_TP_LSB; end
                        CMD_TP_LSB:     begin state_d = ST_CMD; idx_d = CMD_TP_ON;  end
                        CMD_TP_ON:      state_d = ST_SETTLE;
                        default: begin
                            state_d = ST_DONE;
                            ready_d = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                    match_d = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CHECK: begin
                match_d = match_nx;
                tmo_d   = tmo_inc;
                // A pass on the same cycle as the timeout takes priority.
                if (match_nx == MATCH_LIM) begin
                    state_d = ST_CMD;
                    idx_d   = CMD_TP_OFF;
                end else if (tmo_inc == TIMEOUT_LIM) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_CMD;
                        idx_d   = CMD_SOFT_RESET;
                    end else begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end
                end
            end
            ST_DONE, ST_FAIL: begin
                if (state_q == ST_DONE && FR_in != FR_EXPECT) begin
                    ferr_d = 1'b1;
                end
                if (start_in) begin
                    state_d = ST_CMD;
                    idx_d   = CMD_SOFT_RESET;
                    ready_d = 1'b0;
                    fail_d  = 1'b0;
                    ferr_d  = 1'b0;
                    retry_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Address/data are captured on entry to CMD and held until the next command.
        trig_d = (state_d == ST_CMD);
        if (trig_d) begin
            addr_d = rom_addr;
            data_d = rom_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            match_q <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
            trig_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            trig_q  <= trig_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            fail_q  <= fail_d;
            ferr_q  <= ferr_d;
        end
    end

    assign cmd_trig_out  = trig_q;
    assign cmd_addr_out  = addr_q;
    assign cmd_data_out  = data_q;
    assign ready_out     = ready_q;
    assign fail_out      = fail_q;
    assign frame_err_out = ferr_q;
    assign retry_out     = (32'(retry_q) >= 3) ? 2'd3 : 2'(retry_q);
    assign dbg_state_out = state_q;

endmodule

// File: tb/tb_ltc2195_init_seq.sv
// Directed bench for ltc2195_init_seq: expected SPI strobes are queued by the
// stimulus and popped by a monitor; status outputs are checked inline.
module tb_ltc2195_init_seq;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAIL  = 3'd6;

    localparam logic [31:0] STB0 = 32'h0000_0080;
    localparam logic [31:0] STB1 = 32'h0004_0055;
    localparam logic [31:0] STB2 = 32'h0003_00AA;
    localparam logic [31:0] STB3 = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [15:0] adc0, adc1;
    logic [3:0]  fr;
    logic        cmd_trig_out;
    logic [15:0] cmd_addr_out, cmd_data_out;
    logic        ready_out, fail_out, frame_err_out;
    logic [1:0]  retry_out;
    logic [2:0]  dbg_state_out;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_pass = 0;
    int          n_total = 0;

    ltc2195_init_seq #(
        .CMD_GAP       (8),
        .SETTLE_CYCLES (16),
        .CHECK_COUNT   (4),
        .CHECK_TIMEOUT (64),
        .MAX_RETRIES   (3),
        .TEST_PATTERN  (16'h2A55),
        .FR_EXPECT     (4'b0011)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_in      (start_in),
        .ADC0_in       (adc0),
        .ADC1_in       (adc1),
        .FR_in         (fr),
        .cmd_trig_out  (cmd_trig_out),
        .cmd_addr_out  (cmd_addr_out),
        .cmd_data_out  (cmd_data_out),
        .ready_out     (ready_out),
        .fail_out      (fail_out),
        .frame_err_out (frame_err_out),
        .retry_out     (retry_out),
        .dbg_state_out (dbg_state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cmd_trig_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got %h/%h expected none", cmd_addr_out, cmd_data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe", {cmd_addr_out, cmd_data_out}, mon_exp);
            end
        end
    end

    task automatic push_setup();
        exp_q.push_back(STB0);
        exp_q.push_back(STB1);
        exp_q.push_back(STB2);
    endtask

    task automatic push_full();
        push_setup();
        exp_q.push_back(STB3);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (dbg_state_out !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dbg_state_out), 32'(s));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_flags"}, {cmd_trig_out, ready_out, fail_out, frame_err_out, retry_out}, 32'h0);
        check({name, "_cmd"}, {cmd_addr_out, cmd_data_out}, 32'h0);
    endtask

    task automatic check_trained(input string name);
        check({name, "_ready"}, 32'(ready_out), 32'h1);
        check({name, "_fail"}, 32'(fail_out), 32'h0);
        check({name, "_retry"}, 32'(retry_out), 32'h0);
        repeat (3) @(negedge clk);
        check({name, "_strobes_left"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        start_in = 1'b0;
        adc0     = 16'h2A55;
        adc1     = 16'h2A55;
        fr       = 4'b0011;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_state", 32'(dbg_state_out), 32'(S_IDLE));

        // Clean link
        push_full();
        rst = 1'b0;
        wait_state(S_DONE, 500, "clean_done");
        check("clean_frame_err", 32'(frame_err_out), 32'h0);
        check_trained("clean");

        // Frame glitch in DONE, then restart clears it
        fr = 4'b0110;
        @(negedge clk);
        fr = 4'b0011;
        check("glitch_frame_err", 32'(frame_err_out), 32'h1);
        check("glitch_ready", 32'(ready_out), 32'h1);
        repeat (5) @(negedge clk);
        check("glitch_frame_err_sticky", 32'(frame_err_out), 32'h1);
        push_full();
        pulse_start();
        check("restart_ready_cleared", 32'(ready_out), 32'h0);
        check("restart_frame_err_cleared", 32'(frame_err_out), 32'h0);
        wait_state(S_DONE, 500, "restart_done");
        check("restart_frame_err", 32'(frame_err_out), 32'h0);
        check_trained("restart");

        // Intermittent error: 3rd matching cycle corrupts ADC1, count restarts
        push_full();
        pulse_start();
        wait_state(S_CHECK, 200, "intermit_check_entry");
        n = 0;
        while (dbg_state_out === S_CHECK && n < 100) begin
            n++;
            adc1 = (n == 3) ? 16'h0000 : 16'h2A55;
            @(negedge clk);
        end
        adc1 = 16'h2A55;
        check("intermit_check_cycles", n, 32'd7);
        wait_state(S_DONE, 200, "intermit_done");
        check_trained("intermit");

        // start_in during CHECK is ignored
        push_full();
        pulse_start();
        wait_state(S_CHECK, 200, "ignore_check_entry");
        pulse_start();
        wait_state(S_DONE, 200, "ignore_done");
        check_trained("ignore");

        // Dead link: four attempts, then FAIL
        adc0 = 16'h0000;
        adc1 = 16'h0000;
        repeat (4) push_setup();
        pulse_start();
        wait_state(S_FAIL, 2000, "dead_fail_state");
        check("dead_fail", 32'(fail_out), 32'h1);
        check("dead_retry", 32'(retry_out), 32'h3);
        check("dead_ready", 32'(ready_out), 32'h0);
        repeat (20) @(negedge clk);
        check("dead_strobes_left", exp_q.size(), 32'h0);
        check("dead_trig_quiet", 32'(cmd_trig_out), 32'h0);

        // Reset during GAP after command 1
        adc0 = 16'h2A55;
        adc1 = 16'h2A55;
        exp_q.push_back(STB0);
        exp_q.push_back(STB1);
        pulse_start();
        check("rerun_fail_cleared", 32'(fail_out), 32'h0);
        check("rerun_retry_cleared", 32'(retry_out), 32'h0);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("midrst_in_gap", 32'(dbg_state_out), 32'(S_GAP));
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(negedge clk);
        check("midrst_state", 32'(dbg_state_out), 32'(S_IDLE));
        push_full();
        rst = 1'b0;
        wait_state(S_DONE, 500, "midrst_done");
        check_trained("midrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
